// File: rtl/softex_pkg.sv
// Shared SoftEx types: slot contents, slot request/update operations and the
// registered slot response bundle.
package softex_pkg;

    localparam int SLOT_ADDR_BITS = 4;

    typedef struct packed {
        logic [15:0] maximum;
        logic [31:0] denominator;
        logic        valid;
    } slot_t;

    typedef enum logic {
        SLOT_ALLOC = 1'b0,
        SLOT_LOAD  = 1'b1
    } slot_req_op_e;

    typedef struct packed {
        slot_req_op_e              op;
        logic [SLOT_ADDR_BITS-1:0] addr;
    } slot_req_op_t;

    typedef enum logic {
        SLOT_UPDATE = 1'b0,
        SLOT_FREE   = 1'b1
    } slot_update_op_e;

    typedef struct packed {
        slot_update_op_e           op;
        logic [SLOT_ADDR_BITS-1:0] addr;
        logic [15:0]               maximum;
        logic [31:0]               denominator;
    } slot_update_op_t;

    typedef struct packed {
        logic [SLOT_ADDR_BITS-1:0] addr;
        slot_t                     slot;
        logic                      err;
    } slot_rsp_t;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_RESP = 1'b1
    } slot_fsm_e;

endpackage

// File: rtl/softex_slot_regfile_free_finder.sv
// softex_slot_free_finder: combinational priority encoder returning the
// lowest-index slot whose alloc bit is clear.
module softex_slot_free_finder
    import softex_pkg::*;
#(
    parameter int N_SLOTS = 8
) (
    input  logic [N_SLOTS-1:0]        alloc_i,
    output logic [SLOT_ADDR_BITS-1:0] index_o,
    output logic                      any_free_o
);

    always_comb begin
        index_o    = '0;
        any_free_o = 1'b0;
        // Scan downwards so the last hit is the lowest free index.
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!alloc_i[i]) begin
                index_o    = SLOT_ADDR_BITS'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/softex_slot_regfile.sv
// Per-slot softmax partial-state register file answering ALLOC/LOAD requests
// with a registered response. Optional SOFTEX_SLOT_OCC_CNT_EN adds occupancy_o.
module softex_slot_regfile
    import softex_pkg::*;
#(
    parameter int          N_SLOTS   = 8,
    parameter logic [15:0] MAX_RESET = 16'hFF80
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  slot_req_op_t              req_op_i,
    input  logic                      update_valid_i,
    input  slot_update_op_t           update_op_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [SLOT_ADDR_BITS-1:0] rsp_addr_o,
    output slot_t                     rsp_slot_o,
    output logic                      rsp_err_o,
    output logic                      busy_o
`ifdef SOFTEX_SLOT_OCC_CNT_EN
    ,
    output logic [$clog2(N_SLOTS+1)-1:0] occupancy_o
`endif
);

    // Handshake: a request is taken on req_valid_i && req_ready_o; the response
    // is presented one cycle later and held until rsp_valid_o && rsp_ready_i.

    logic [N_SLOTS-1:0]        alloc_q, alloc_d;
    slot_t                     slots_q [N_SLOTS];
    slot_t                     slots_d [N_SLOTS];
    slot_fsm_e                 state_q, state_d;
    slot_rsp_t                 rsp_q, rsp_d;

    logic [SLOT_ADDR_BITS-1:0] free_idx;
    logic                      any_free;
    logic                      req_fire;
    logic                      alloc_ok;
    logic                      freed;
    logic                      load_ok;
    slot_t                     load_slot;
    slot_t                     new_slot;

    softex_slot_free_finder #(
        .N_SLOTS (N_SLOTS)
    ) u_free_finder (
        .alloc_i    (alloc_q),
        .index_o    (free_idx),
        .any_free_o (any_free)
    );

    assign rsp_valid_o = (state_q == SLOT_RESP);
    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign rsp_addr_o  = rsp_q.addr;
    assign rsp_slot_o  = rsp_q.slot;
    assign rsp_err_o   = rsp_q.err;
    assign busy_o      = |alloc_q;

    always_comb begin
        alloc_d   = alloc_q;
        slots_d   = slots_q;
        state_d   = state_q;
        rsp_d     = rsp_q;
        alloc_ok  = 1'b0;
        freed     = 1'b0;
        load_ok   = 1'b0;
        load_slot = '0;
        new_slot  = '{maximum: MAX_RESET, denominator: 32'h0, valid: 1'b0};

        for (int i = 0; i < N_SLOTS; i++) begin
            if (update_valid_i && (update_op_i.addr == SLOT_ADDR_BITS'(i)) && alloc_q[i]) begin
                if (update_op_i.op == SLOT_UPDATE) begin
                    slots_d[i] = '{maximum:     update_op_i.maximum,
                                   denominator: update_op_i.denominator,
                                   valid:       1'b1};
                end else begin
                    alloc_d[i] = 1'b0;
                    slots_d[i] = '0;
                    freed      = 1'b1;
                end
            end
        end

        // LOAD reads the post-update view so same-cycle UPDATE/FREE are bypassed.
        for (int i = 0; i < N_SLOTS; i++) begin
            if (req_op_i.addr == SLOT_ADDR_BITS'(i)) begin
                load_ok   = alloc_d[i];
                load_slot = slots_d[i];
            end
        end

        if (req_fire) begin
            state_d = SLOT_RESP;
            if (req_op_i.op == SLOT_ALLOC) begin
                if (any_free) begin
                    alloc_ok = 1'b1;
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (free_idx == SLOT_ADDR_BITS'(i)) begin
                            alloc_d[i] = 1'b1;
                            slots_d[i] = new_slot;
                        end
                    end
                    rsp_d = '{addr: free_idx, slot: new_slot, err: 1'b0};
                end else begin
                    rsp_d = '{addr: '0, slot: '0, err: 1'b1};
                end
            end else begin
                rsp_d.addr = req_op_i.addr;
                rsp_d.slot = load_ok ? load_slot : '0;
                rsp_d.err  = !load_ok;
            end
        end else if (rsp_ready_i) begin
            state_d = SLOT_IDLE;
        end

        if (clear_i) begin
            alloc_d  = '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_d[i] = '0;
            end
            state_d  = SLOT_IDLE;
            rsp_d    = '0;
            alloc_ok = 1'b0;
            freed    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alloc_q <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                slots_q[i] <= '0;
            end
            state_q <= SLOT_IDLE;
            rsp_q   <= '0;
        end else begin
            alloc_q <= alloc_d;
            slots_q <= slots_d;
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef SOFTEX_SLOT_OCC_CNT_EN
    localparam int OCC_W = $clog2(N_SLOTS + 1);

    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (clear_i) begin
            occ_d = '0;
        end else if (alloc_ok && !freed) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (freed && !alloc_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy_o = occ_q;
`else
    logic unused_occ;
    assign unused_occ = alloc_ok ^ freed;
`endif

endmodule

// File: doc/softex_slot_regfile.md
Name: softex_slot_regfile

Overview:
- Responder side of the SoftEx slot protocol; accelerator controller is initiator.
- Holds per-slot softmax partial state (running maximum, denominator) across jobs.
- Serves ALLOC/LOAD requests through a valid/ready request channel with a registered response.
- Applies UPDATE/FREE operations fire-and-forget.

Parameters:
- N_SLOTS, 8: number of slots; 2 ≤ N_SLOTS ≤ 2**SLOT_ADDR_BITS.
- MAX_RESET, 16'hFF80: value loaded into maximum on ALLOC (-inf in FP16ALT).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- clear_i  in  1  synchronous clear of all slots, same effect as reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_op_i  in  slot_req_op_t  op ALLOC/LOAD plus addr (addr ignored for ALLOC)
- update_valid_i  in  1  update strobe, always accepted
- update_op_i  in  slot_update_op_t  op UPDATE/FREE, addr, maximum, denominator
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_addr_o  out  SLOT_ADDR_BITS  allocated or loaded slot index
- rsp_slot_o  out  slot_t  slot contents (maximum, denominator, valid)
- rsp_err_o  out  1  ALLOC with no free slot, or LOAD of unallocated or out-of-range addr
- busy_o  out  1  any slot allocated

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset or clear_i: all alloc bits are 0, all slot_t entries are 0.
- Output reset values: rsp_valid_o=0, rsp_addr_o=0, rsp_slot_o=0, rsp_err_o=0, req_ready_o=1, busy_o=0.
- Per-slot state:
  - alloc bit.
  - slot_t entry. Its valid field is 1 only after the first UPDATE since ALLOC.
- FSM IDLE/RESP:
  - Output register: req_ready_o = !rsp_valid_o || rsp_ready_i.
  - Request fires on req_valid_i && req_ready_o.
  - Response appears the next cycle: latency 1.
  - Response holds stable until rsp_valid_o && rsp_ready_i.
  - Back-to-back requests give one response per cycle.
- ALLOC:
  - Picks the lowest-index slot with alloc=0.
  - Sets alloc=1, maximum=MAX_RESET, denominator=0, valid=0.
  - rsp_addr_o = index; rsp_slot_o = new contents.
  - If no slot is free: rsp_err_o=1, rsp_addr_o=0, state unchanged.
- LOAD:
  - rsp_slot_o = entry at addr; rsp_addr_o = addr.
  - If addr ≥ N_SLOTS or alloc=0: rsp_err_o=1 and rsp_slot_o=0.
- UPDATE (single cycle):
  - Writes maximum and denominator, sets valid=1, if alloc=1.
  - Otherwise dropped silently. Out-of-range addr is dropped.
- FREE (single cycle): clears alloc and zeroes the entry. FREE on an unallocated slot has no effect.
- Same-cycle collisions:
  - Update and request are both serviced.
  - LOAD to the same addr as an UPDATE returns the updated values (bypass).
  - LOAD to the same addr as a FREE returns err.
  - ALLOC never returns a slot being freed that same cycle; the freed slot is available from the next cycle.
- A captured response is unaffected by later updates.
- busy_o = OR of alloc bits, registered view of current state.
- Reset mid-response drops the pending response.

Optional Feature:
- SOFTEX_SLOT_OCC_CNT_EN:
  - Defined: adds output occupancy_o [$clog2(N_SLOTS+1)], a registered count of allocated slots.
    - +1 on successful ALLOC, -1 on effective FREE, unchanged when both occur in one cycle.
    - Reset and clear_i set it to 0.
  - Undefined: port and counter are absent.

Decomposition:
- Reuse slot_t, slot_req_op_t, slot_update_op_t, slot_req_op_e, slot_update_op_e and SLOT_ADDR_BITS from softex_pkg.
- Add to softex_pkg a packed slot_rsp_t {addr, slot_t slot, err}; rsp_* ports may be bundled from it.
- One sub-module: softex_slot_free_finder, a combinational lowest-free-index priority encoder producing index and any_free.

Test Plan:
- Reset, then 9 ALLOCs with N_SLOTS=8 -> addrs 0..7, each with maximum=16'hFF80, denominator=0, valid=0; 9th has rsp_err_o=1.
- UPDATE addr 3 (max 16'h3F80, den 32'h40000000), then LOAD 3 -> rsp_slot_o={3F80, 40000000, 1}, err=0.
- FREE 5 then ALLOC -> rsp_addr_o=5; FREE 5 and ALLOC in the same cycle -> err when full, addr 5 on the next ALLOC.
- Hold rsp_ready_i=0 for 3 cycles after a LOAD -> response stable, req_ready_o=0; release -> next request accepted the same cycle.
- LOAD 2 with a same-cycle UPDATE 2 -> response shows the new values; LOAD 7 when unallocated -> err=1, slot=0.
- Assert rst_ni low while rsp_valid_o=1 -> all outputs return to reset values asynchronously; with SOFTEX_SLOT_OCC_CNT_EN, occupancy_o=0.
